// File: rtl/unidade_controle_if.sv
// unidade_controle_if: instruction issue handshake between an instruction
// source and the unidade_controle sequencer.
//   instr       : 12-bit instruction word, sampled on the accepting edge
//   instr_valid : instr holds a valid instruction
//   ready       : sequencer is idle and will accept an instruction
//   done        : one-cycle pulse when an instruction completes
// Modports: master = instruction source, slave = sequencer.
interface unidade_controle_if;
  logic [11:0] instr;
  logic        instr_valid;
  logic        ready;
  logic        done;

  modport master (
    output instr,
    output instr_valid,
    input  ready,
    input  done
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output ready,
    output done
  );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle: sequencing control unit for the 4-bit datapath.
// Accepts one instruction at a time over the handshake bus, steps the
// datapath through operand fetch, execution and write-back, and holds the
// carry flag C between instructions.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : instr / instr_valid / ready / done handshake (slave side)
//   carry_out  : carry from the datapath ULA
//   sel12      : 0 loads regA, 1 loads regB
//   escrita    : register-file write enable
//   sel21      : write-data source (0 = dados, 1 = ULA result)
//   reg_addr   : register-file address
//   operacao   : ULA operation select
//   carry_in   : carry into the ULA
//   dados      : immediate data
//   carry_flag : stored carry flag C
module unidade_controle (
  input  logic                     clk,
  input  logic                     reset,
  unidade_controle_if.slave        bus,
  input  logic                     carry_out,
  output logic                     sel12,
  output logic                     escrita,
  output logic                     sel21,
  output logic [1:0]               reg_addr,
  output logic [2:0]               operacao,
  output logic                     carry_in,
  output logic [3:0]               dados,
  output logic                     carry_flag
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WR_ALU = 3'd3,
    WR_LDI = 3'd4,
    MISC   = 3'd5
  } state_t;

  localparam logic [1:0] CLS_NOP  = 2'b00;
  localparam logic [1:0] CLS_LDI  = 2'b01;
  localparam logic [1:0] CLS_ALU  = 2'b10;
  localparam logic [1:0] CLS_CLRC = 2'b11;

  state_t      state_reg, state_next;
  logic [11:0] instr_reg;
  logic        c_reg;
  logic        done_reg;
  logic        accept;

  // Fields of the latched instruction
  logic [1:0] rd, rs1, rs2;
  logic [2:0] op;
  logic       cen;
  logic [3:0] imm;

  assign rd  = instr_reg[9:8];
  assign rs1 = instr_reg[7:6];
  assign rs2 = instr_reg[5:4];
  assign op  = instr_reg[3:1];
  assign cen = instr_reg[0];
  assign imm = instr_reg[3:0];

  assign accept = (state_reg == IDLE) && bus.instr_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      instr_reg <= '0;
      c_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept)
        instr_reg <= bus.instr;
      // done follows every terminal state by exactly one cycle
      done_reg <= (state_reg == WR_ALU) || (state_reg == WR_LDI) ||
                  (state_reg == MISC);
      if (state_reg == WR_ALU)
        c_reg <= carry_out;
      else if ((state_reg == MISC) && (instr_reg[11:10] == CLS_CLRC))
        c_reg <= 1'b0;
    end
  end

  // Next state. Decode in IDLE uses the incoming word because instr_reg is
  // only written on the accepting edge itself.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.instr_valid) begin
          case (bus.instr[11:10])
            CLS_ALU:  state_next = LOAD_A;
            CLS_LDI:  state_next = WR_LDI;
            default:  state_next = MISC;
          endcase
        end
      end
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = WR_ALU;
      WR_ALU:  state_next = IDLE;
      WR_LDI:  state_next = IDLE;
      MISC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs. Because they depend only on state_reg, an asynchronous
  // reset drops escrita immediately.
  always_comb begin
    bus.ready = 1'b0;
    sel12     = 1'b1;
    escrita   = 1'b0;
    sel21     = 1'b0;
    reg_addr  = 2'd0;
    operacao  = 3'd0;
    dados     = 4'd0;
    carry_in  = 1'b0;
    case (state_reg)
      IDLE:   bus.ready = 1'b1;
      LOAD_A: begin
        reg_addr = rs1;
        sel12    = 1'b0;
        operacao = op;
      end
      LOAD_B: begin
        reg_addr = rs2;
        operacao = op;
      end
      WR_ALU: begin
        reg_addr = rd;
        sel21    = 1'b1;
        escrita  = 1'b1;
        operacao = op;
        carry_in = cen & c_reg;
      end
      WR_LDI: begin
        reg_addr = rd;
        dados    = imm;
        escrita  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done   = done_reg;
  assign carry_flag = c_reg;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;
  logic       clk;
  logic       reset;
  logic       carry_out;
  logic       sel12, escrita, sel21, carry_in, carry_flag;
  logic [1:0] reg_addr;
  logic [2:0] operacao;
  logic [3:0] dados;

  int errors = 0;
  int checks = 0;
  int wr_count;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .carry_out  (carry_out),
    .sel12      (sel12),
    .escrita    (escrita),
    .sel21      (sel21),
    .reg_addr   (reg_addr),
    .operacao   (operacao),
    .carry_in   (carry_in),
    .dados      (dados),
    .carry_flag (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full ALU instruction with per-cycle checks; expected values given by hand.
  task automatic run_alu(input string name, input logic [11:0] word,
                         input logic [1:0] e_rd, input logic [1:0] e_rs1,
                         input logic [1:0] e_rs2, input logic [2:0] e_op,
                         input logic cout, input logic e_cin, input logic e_c);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check({name, " c1 sel12"},    {11'd0, sel12}, 12'd0);
    check({name, " c1 reg_addr"}, {10'd0, reg_addr}, {10'd0, e_rs1});
    check({name, " c1 ready"},    {11'd0, bus.ready}, 12'd0);
    check({name, " c1 escrita"},  {11'd0, escrita}, 12'd0);
    tick();
    check({name, " c2 sel12"},    {11'd0, sel12}, 12'd1);
    check({name, " c2 reg_addr"}, {10'd0, reg_addr}, {10'd0, e_rs2});
    check({name, " c2 escrita"},  {11'd0, escrita}, 12'd0);
    tick();
    check({name, " c3 escrita"},  {11'd0, escrita}, 12'd1);
    check({name, " c3 sel21"},    {11'd0, sel21}, 12'd1);
    check({name, " c3 reg_addr"}, {10'd0, reg_addr}, {10'd0, e_rd});
    check({name, " c3 operacao"}, {9'd0, operacao}, {9'd0, e_op});
    check({name, " c3 carry_in"}, {11'd0, carry_in}, {11'd0, e_cin});
    check({name, " c3 done"},     {11'd0, bus.done}, 12'd0);
    carry_out = cout;
    tick();
    carry_out = 1'b0;
    check({name, " c4 done"},     {11'd0, bus.done}, 12'd1);
    check({name, " c4 ready"},    {11'd0, bus.ready}, 12'd1);
    check({name, " c4 escrita"},  {11'd0, escrita}, 12'd0);
    check({name, " c4 C"},        {11'd0, carry_flag}, {11'd0, e_c});
    $display("ALU %s instr=%h carry_in=%0b carry_out=%0b C=%0b", name, word, carry_in, cout, carry_flag);
  endtask

  // NOP / CLRC: no write, done two cycles after acceptance.
  task automatic run_misc(input string name, input logic [11:0] word, input logic e_c);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check({name, " c1 escrita"}, {11'd0, escrita}, 12'd0);
    check({name, " c1 ready"},   {11'd0, bus.ready}, 12'd0);
    check({name, " c1 done"},    {11'd0, bus.done}, 12'd0);
    tick();
    check({name, " c2 done"},    {11'd0, bus.done}, 12'd1);
    check({name, " c2 escrita"}, {11'd0, escrita}, 12'd0);
    check({name, " c2 C"},       {11'd0, carry_flag}, {11'd0, e_c});
    $display("MISC %s instr=%h C=%0b", name, word, carry_flag);
  endtask

  task automatic run_ldi(input string name, input logic [11:0] word,
                         input logic [1:0] e_rd, input logic [3:0] e_imm);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check({name, " escrita"},  {11'd0, escrita}, 12'd1);
    check({name, " sel21"},    {11'd0, sel21}, 12'd0);
    check({name, " reg_addr"}, {10'd0, reg_addr}, {10'd0, e_rd});
    check({name, " dados"},    {8'd0, dados}, {8'd0, e_imm});
    check({name, " ready"},    {11'd0, bus.ready}, 12'd0);
    check({name, " done0"},    {11'd0, bus.done}, 12'd0);
    tick();
    check({name, " done"},     {11'd0, bus.done}, 12'd1);
    check({name, " ready1"},   {11'd0, bus.ready}, 12'd1);
    check({name, " escrita0"}, {11'd0, escrita}, 12'd0);
    $display("LDI %s instr=%h", name, word);
  endtask

  initial begin
    reset           = 1'b0;
    carry_out       = 1'b0;
    bus.instr       = 12'h000;
    bus.instr_valid = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst ready",    {11'd0, bus.ready}, 12'd1);
    check("rst done",     {11'd0, bus.done}, 12'd0);
    check("rst escrita",  {11'd0, escrita}, 12'd0);
    check("rst sel12",    {11'd0, sel12}, 12'd1);
    check("rst C",        {11'd0, carry_flag}, 12'd0);
    check("rst reg_addr", {10'd0, reg_addr}, 12'd0);
    $display("RESET ready=%0b escrita=%0b C=%0b", bus.ready, escrita, carry_flag);
    reset = 1'b1;
    tick();

    run_ldi("ldi_r2_9", 12'h609, 2'd2, 4'd9);

    // C=0, cen=1 -> carry_in 0; carry_out 1 sets C
    run_alu("alu_c0",   12'hB67, 2'd3, 2'd1, 2'd2, 3'd3, 1'b1, 1'b0, 1'b1);
    // C=1, cen=1 -> carry_in 1; carry_out 0 clears C
    run_alu("alu_cin",  12'hB67, 2'd3, 2'd1, 2'd2, 3'd3, 1'b0, 1'b1, 1'b0);
    run_alu("alu_set",  12'hB67, 2'd3, 2'd1, 2'd2, 3'd3, 1'b1, 1'b0, 1'b1);
    // C=1, cen=0 -> carry_in 0; carry_out 1 keeps C=1
    run_alu("alu_cen0", 12'hB66, 2'd3, 2'd1, 2'd2, 3'd3, 1'b1, 1'b0, 1'b1);

    // Reset in WR_ALU of 0x9D5 (rd=1 rs1=3 rs2=1 op=2 cen=1), C=1 beforehand
    bus.instr       = 12'h9D5;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("rstmid c1 reg_addr", {10'd0, reg_addr}, 12'd3);
    tick();
    tick();
    check("rstmid wr escrita", {11'd0, escrita}, 12'd1);
    check("rstmid wr operacao", {9'd0, operacao}, 12'd2);
    #2 reset = 1'b0;
    #1;
    check("rstmid escrita async", {11'd0, escrita}, 12'd0);
    check("rstmid C",             {11'd0, carry_flag}, 12'd0);
    check("rstmid ready",         {11'd0, bus.ready}, 12'd1);
    tick();
    check("rstmid no done",       {11'd0, bus.done}, 12'd0);
    $display("RESET-MID escrita=%0b C=%0b done=%0b", escrita, carry_flag, bus.done);
    reset = 1'b1;
    tick();
    check("rstmid ready after",   {11'd0, bus.ready}, 12'd1);
    run_ldi("ldi_r3_5", 12'h705, 2'd3, 4'd5);

    // CLRC with C=1, then NOP keeps C=0
    run_alu("alu_set2", 12'hB67, 2'd3, 2'd1, 2'd2, 3'd3, 1'b1, 1'b0, 1'b1);
    run_misc("clrc", 12'hC00, 1'b0);
    run_misc("nop",  12'h000, 1'b0);

    // Back-to-back LDIs with instr_valid held high
    wr_count        = 0;
    bus.instr       = 12'h609;
    bus.instr_valid = 1'b1;
    tick();
    if (escrita) wr_count++;
    check("b2b c1 ready",    {11'd0, bus.ready}, 12'd0);
    check("b2b c1 dados",    {8'd0, dados}, 12'd9);
    tick();
    if (escrita) wr_count++;
    check("b2b c2 done",     {11'd0, bus.done}, 12'd1);
    check("b2b c2 ready",    {11'd0, bus.ready}, 12'd1);
    bus.instr = 12'h601;
    tick();
    if (escrita) wr_count++;
    check("b2b c3 ready",    {11'd0, bus.ready}, 12'd0);
    check("b2b c3 reg_addr", {10'd0, reg_addr}, 12'd2);
    check("b2b c3 dados",    {8'd0, dados}, 12'd1);
    bus.instr_valid = 1'b0;
    tick();
    if (escrita) wr_count++;
    check("b2b c4 done",     {11'd0, bus.done}, 12'd1);
    check("b2b escrita pulses", 12'(wr_count), 12'd2);
    $display("B2B escrita_pulses=%0d", wr_count);
    tick();
    check("b2b idle done",   {11'd0, bus.done}, 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
